// File: rtl/cpu_serial_pkg.sv
// Shared definitions for the CPU serial link (transmitter now, receiver later).
package cpu_serial_pkg;

  // Frame phase: start bit, eight data bits, stop bit, then idle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serial_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_port_if.sv
// Byte-load / serial-out bundle between the CPU output register and the
// transmitter.
//
// Handshake: the producer raises en with a byte on I for one cycle; the byte
// is taken on a rising clk edge where en=1 and busy=0. While busy=1, en is
// ignored and nothing is queued. done pulses for one cycle when the stop bit
// has completed, and busy falls in that same cycle. state is a debug view of
// the transmitter FSM.
interface serial_tx_port_if;
  import cpu_serial_pkg::*;

  logic          en;
  logic [7:0]    I;
  logic          tx;
  logic          busy;
  logic          done;
  serial_state_e state;

  modport master (output en, I, input tx, busy, done, state);
  modport slave  (input en, I, output tx, busy, done, state);
endinterface

// File: rtl/serial_tx_port_bit_timer.sv
// Bit-period timer: counts clk cycles within one serial bit and flags the
// last cycle of the period so the FSM can move to the next bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  // Count 0..CLKS_PER_BIT-1 and wrap; held at 0 while cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_tx_port.sv
// Parallel-to-serial transmitter: takes a byte on a load strobe and sends
// it as start(0), 8 data bits LSB first, stop(1). All outputs registered.
module serial_tx_port
  import cpu_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_tx_port_if.slave  bus
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  serial_state_e state_q;
  logic [7:0]    shift_q;
  logic [BW-1:0] bit_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          tick;

  // The timer is held at zero while idle so the accept edge restarts it and
  // the first tick lands on the last cycle of the start bit.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (tick)
  );

  // Frame FSM: advances one bit per timer tick, driving tx from the shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      bit_q   <= '0;
      tx_q    <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.en && !busy_q) begin
            shift_q <= bus.I;
            tx_q    <= START_LEVEL;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_q == LAST_BIT) begin
              tx_q    <= STOP_LEVEL;
              state_q <= STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 1'b1;
            end
          end
        end
        STOP: begin
          // busy drops together with the done pulse so a new byte can be
          // accepted in the done cycle itself.
          if (tick) begin
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: doc/serial_tx_port.md
Name: serial_tx_port

Overview:
- Parallel-to-serial transmitter on the consuming side of the CPU's 8-bit output register.
- Accepts a byte on a single-cycle load strobe and shifts it out on one line.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Reports busy while a frame is in flight and a one-cycle done pulse when the frame completes.

Parameters:
- CLKS_PER_BIT, 4, clk cycles each serial bit is held on tx; legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- en  input  1  load strobe; byte on I accepted when en=1 and busy=0
- I  input  8  parallel byte to transmit
- tx  output  1  serial line; idles high
- busy  output  1  high while a frame is being sent
- done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- All outputs are registered and update on posedge clk.
- Reset (rst=1 at an edge):
  - Outputs: tx=1, busy=0, done=0.
  - Internal state: state=IDLE, bit counter=0, cycle counter=0, shift register=8'h00.
  - rst overrides en.
- States:
  - IDLE -> START: on en && !busy.
  - START -> DATA: after CLKS_PER_BIT cycles.
  - DATA -> STOP: after 8 bits of CLKS_PER_BIT cycles each.
  - STOP -> IDLE: after CLKS_PER_BIT cycles.
- Accept edge (en=1, busy=0): latch I into the shift register; tx<=0, busy<=1, cycle counter<=0.
- Bit timing:
  - The cycle counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - tx changes only on bit boundaries.
- Data bits:
  - The shift register shifts right one place per bit boundary; tx takes the current LSB.
  - The bit counter runs 0..7; the DATA->STOP move happens when it reaches 7 and the cycle counter wraps.
- Frame timing:
  - For an accept at edge E, tx is low during cycles E+1..E+N, where N=CLKS_PER_BIT.
  - Data bit k occupies cycles E+N(k+1)+1..E+N(k+2).
  - The stop bit occupies E+9N+1..E+10N.
- Completion:
  - At edge E+10N: busy<=0, done<=1 for exactly one cycle, tx stays 1.
  - busy is therefore high for exactly 10*N cycles.
- en while busy=1: ignored. No queuing and no change to the frame in flight; I is don't-care.
- Back-to-back frames:
  - en is accepted in the done cycle, since busy=0 there.
  - The next start bit begins one cycle later, giving a minimum 1-cycle idle-high gap between frames.
- I is sampled only on the accept edge; later changes to I have no effect.
- Reset mid-frame: the frame is aborted and outputs take their reset values at that edge, with no done pulse. en on the edge after rst deasserts is accepted normally.
- CLKS_PER_BIT=1: each bit lasts one cycle; a frame takes 10 cycles.
- Cycle-counter width: $clog2(CLKS_PER_BIT), minimum 1 bit.

Decomposition:
- Shared package cpu_serial_pkg contains:
  - the state enum: IDLE, START, DATA, STOP (2-bit);
  - FRAME_BITS=10, DATA_BITS=8;
  - START_LEVEL=1'b0, STOP_LEVEL=1'b1, IDLE_LEVEL=1'b1.
- A future receiver reuses the same package.
- Sub-module bit_timer:
  - parameterised by CLKS_PER_BIT;
  - inputs clk, rst, clr; output tick;
  - tick pulses on the last cycle of each bit period.
- The top level holds the FSM, the shift register and the bit counter.

Test Plan:
- Reset: hold rst for 3 cycles with en=1, I=8'hFF -> tx=1, busy=0, done=0 throughout; no frame starts.
- Single frame, CLKS_PER_BIT=4, send 8'hA5 at edge E:
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles;
  - busy high for cycles E+1..E+40;
  - done=1 only in cycle E+41.
- en pulsed with I=8'h3C at E+10, mid frame -> ignored; the 8'hA5 frame is unchanged and no second frame follows.
- Back-to-back: en with I=8'h00 in the done cycle of the 8'hA5 frame -> one idle-high cycle, then start bit; data all 0; stop bit 1; second done 41 cycles after the first.
- Reset mid-frame: rst=1 at E+20 -> tx=1 and busy=0 from the next cycle; done never pulses. en with I=8'h81 afterwards -> correct frame 0,1,0,0,0,0,0,0,1,1.
- CLKS_PER_BIT=1 with 8'hFF -> tx=0 for 1 cycle, then 1 for 9 cycles; busy high for 10 cycles; done on cycle 11.
